// File: rtl/axis_spi_rx_packer.sv
// rtl/axis_spi_rx_packer.sv - packs SPI receive beats MSB-first into words and buffers them in a FIFO.
// Optional saturating drop counter enabled by defining AXIS_SPI_RX_DROP_CNT_EN.
module axis_spi_rx_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                                     clk_i,
  input  logic                                     arstn_i,
  input  logic [DATA_WIDTH-1:0]                    s_axis_tdata_i,
  input  logic                                     s_axis_tvalid_i,
  output logic                                     s_axis_tready_o,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]         m_axis_tdata_o,
  output logic                                     m_axis_tvalid_o,
  input  logic                                     m_axis_tready_i,
  output logic                                     m_axis_tuser_o,
  output logic [$clog2(FIFO_DEPTH):0]              level_o,
  output logic                                     overflow_o,
  input  logic                                     clr_i,
  output logic [15:0]                              drop_cnt_o
);

  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int IDX_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic {EMPTY = 1'b0, PARTIAL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic [IDX_W-1:0]   idx_q;
  logic [OUT_W-1:0]   word_q, word_beat;
  logic [CNT_W-1:0]   idle_q;
  logic               beat, last_beat, timeout_hit, word_done;
  logic               push_valid_q, push_user_q;
  logic [OUT_W-1:0]   push_data_q;

  assign s_axis_tready_o = ready_q;
  assign beat        = s_axis_tvalid_i && ready_q;
  assign last_beat   = (idx_q == IDX_W'(PACK_RATIO - 1));
  // An arriving beat beats the timeout in the same cycle.
  assign timeout_hit = (state_q == PARTIAL) && !beat && (idle_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (beat && !last_beat) state_d = PARTIAL;
      PARTIAL: if ((beat && last_beat) || timeout_hit) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    word_done = (beat && last_beat) || timeout_hit;
    word_beat = word_q;
    if (beat) begin
      for (int k = 0; k < PACK_RATIO; k++) begin
        if (idx_q == IDX_W'(k)) word_beat[OUT_W-1-k*DATA_WIDTH -: DATA_WIDTH] = s_axis_tdata_i;
      end
    end
  end

  // word_q is zeroed after every completion so a flushed word has zero low bytes.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ready_q      <= 1'b0;
      idx_q        <= '0;
      word_q       <= '0;
      idle_q       <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      push_user_q  <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      push_valid_q <= word_done;
      if (word_done) begin
        push_data_q <= word_beat;
        push_user_q <= timeout_hit;
        word_q      <= '0;
        idx_q       <= '0;
      end else if (beat) begin
        word_q <= word_beat;
        idx_q  <= idx_q + 1'b1;
      end
      if (beat || timeout_hit || state_q == EMPTY) idle_q <= '0;
      else                                         idle_q <= idle_q + 1'b1;
    end
  end

  logic [OUT_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [OUT_W:0]   head;
  logic             fifo_valid, full, pop, wr_en, drop;

  assign fifo_valid = (level_q != '0);
  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop        = fifo_valid && m_axis_tready_i;
  assign wr_en      = push_valid_q && (!full || pop);
  assign drop       = push_valid_q && full && !pop;
  assign head       = mem[rd_ptr];

  assign m_axis_tvalid_o = fifo_valid;
  assign m_axis_tdata_o  = fifo_valid ? head[OUT_W-1:0] : '0;
  assign m_axis_tuser_o  = fifo_valid && head[OUT_W];
  assign level_o         = level_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= {push_user_q, push_data_q};
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  logic overflow_q;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)   overflow_q <= 1'b0;
    else if (clr_i) overflow_q <= 1'b0;
    else if (drop)  overflow_q <= 1'b1;
  end

`ifdef AXIS_SPI_RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  assign drop_cnt_o = drop_cnt_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)                              drop_cnt_q <= '0;
    else if (clr_i)                            drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF)   drop_cnt_q <= drop_cnt_q + 16'd1;
  end
`else
  assign drop_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_axis_spi_rx_packer.sv
// tb/tb_axis_spi_rx_packer.sv - scoreboard bench for axis_spi_rx_packer (default parameters).
module tb_axis_spi_rx_packer;

  logic        clk = 1'b0;
  logic        arstn;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic [4:0]  level;
  logic        overflow;
  logic        clr;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  axis_spi_rx_packer dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .m_axis_tuser_o  (m_tuser),
    .level_o         (level),
    .overflow_o      (overflow),
    .clr_i           (clr),
    .drop_cnt_o      (drop_cnt)
  );

`ifdef AXIS_SPI_RX_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [16:0] sb [$];
  logic [16:0] exp_word;
  logic [15:0] m_part;
  int          m_idx;
  bit          sb_en;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_tdata  = b;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    if (m_idx == 0) m_part = {b, 8'h00};
    else            m_part[7:0] = b;
    m_idx++;
    if (m_idx == 2) begin
      if (sb_en) sb.push_back({1'b0, m_part});
      m_idx = 0;
    end
  endtask

  task automatic model_flush();
    sb.push_back({1'b1, m_part});
    m_idx = 0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 200 && level != 0; i++) tick();
    check("drain_level", 32'(level), 32'd0);
    tick();
    check("drain_sb_left", 32'(sb.size()), 32'd0);
    m_tready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (arstn && m_tvalid && m_tready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        exp_word = sb.pop_front();
        check("sb_word", 32'({m_tuser, m_tdata}), 32'(exp_word));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    arstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; clr = 1'b0;
    m_idx = 0; m_part = '0; sb_en = 1'b1;
    #12;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_tdata", 32'({m_tuser, m_tdata}), 32'd0);
    tick();
    arstn = 1'b1;
    check("rel_s_tready_pre", 32'(s_tready), 32'd0);
    tick();
    check("rel_s_tready_post", 32'(s_tready), 32'd1);

    // Basic two-beat pack and push latency.
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("t1_tvalid_c1", 32'(m_tvalid), 32'd0);
    tick();
    check("t1_tvalid_c2", 32'(m_tvalid), 32'd1);
    check("t1_tdata", 32'(m_tdata), 32'hA53C);
    check("t1_tuser", 32'(m_tuser), 32'd0);
    check("t1_level", 32'(level), 32'd1);
    drain();

    // Timeout flush of a partial word.
    send_byte(8'h7E);
    repeat (64) tick();
    check("t2_no_early_flush", 32'(m_tvalid), 32'd0);
    tick();
    check("t2_tvalid", 32'(m_tvalid), 32'd1);
    check("t2_tdata", 32'(m_tdata), 32'h7E00);
    check("t2_tuser", 32'(m_tuser), 32'd1);
    model_flush();
    send_byte(8'h11);
    send_byte(8'h22);
    drain();

    // Overflow: 17 words into a 16-deep FIFO.
    for (int w = 0; w < 17; w++) begin
      if (w == 16) sb_en = 1'b0;
      send_byte(8'(8'h40 + w));
      send_byte(8'(8'h80 + w));
    end
    sb_en = 1'b1;
    repeat (3) tick();
    check("t3_level", 32'(level), 32'd16);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));

    // Push into a full FIFO in the same cycle as a pop succeeds.
    send_byte(8'hC1);
    send_byte(8'hC2);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tick();
    check("t4_level", 32'(level), 32'd16);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'(EXP_DROP));

    // Drop and clr in the same cycle: clear wins.
    sb_en = 1'b0;
    send_byte(8'hD1);
    send_byte(8'hD2);
    sb_en = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_overflow", 32'(overflow), 32'd0);
    check("t4_clr_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t4_clr_level", 32'(level), 32'd16);
    drain();

    // Reset mid-stream discards FIFO contents and partial word.
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (2) tick();
    check("t5_level_pre", 32'(level), 32'd1);
    send_byte(8'h12);
    #2 arstn = 1'b0;
    #1;
    check("t5_level", 32'(level), 32'd0);
    check("t5_tvalid", 32'(m_tvalid), 32'd0);
    check("t5_s_tready", 32'(s_tready), 32'd0);
    sb.delete();
    m_idx = 0;
    @(posedge clk);
    #1 arstn = 1'b1;
    tick();
    check("t5_s_tready_rel", 32'(s_tready), 32'd1);
    send_byte(8'h34);
    send_byte(8'h56);
    tick();
    check("t5_tdata", 32'({m_tuser, m_tdata}), 32'h3456);
    drain();

    // Random traffic with random back-pressure; wraps the pointers many times.
    n_pops = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        m_tready = ($urandom_range(0, 3) != 0);
        tick();
      end
      m_tready = ($urandom_range(0, 3) != 0);
      send_byte(8'($urandom));
    end
    drain();
    check("t6_words", 32'(n_pops), 32'd500);
    check("t6_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
